// File: rtl/median_frame_scheduler.sv
// Frame-level arbiter/sequencer sharing one median_filter between two pixel sources.
module median_frame_scheduler #(
  parameter int unsigned IMAGE_LEN      = 1080,
  parameter int unsigned IMAGE_HEIGHT   = 720,
  parameter int unsigned PIXEL_W        = 8,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned DATA_W        = 3 * PIXEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  output logic [1:0]        grant_o,
  input  logic              src0_valid_i,
  input  logic [DATA_W-1:0] src0_data_i,
  input  logic              src1_valid_i,
  input  logic [DATA_W-1:0] src1_data_i,
  output logic              filt_rst_o,
  output logic              filt_start_o,
  output logic              filt_valid_o,
  output logic [DATA_W-1:0] filt_data_o,
  input  logic              filt_out_valid_i,
  input  logic              filt_done_i,
  output logic              frame_done_o,
  output logic              frame_src_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned FRAME_PIX = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int unsigned EXP_OUT   = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
  localparam int unsigned CNT_W     = $clog2(FRAME_PIX + 1);
  localparam int unsigned CLR_W     = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic              timeout_q, timeout_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        grant_q, grant_d;
  logic              filt_rst_q, filt_rst_d;
  logic              filt_start_q, filt_start_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_src_q, frame_src_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              fwd;

  // Pixel path stays a state-gated mux so pixels reach the filter without added latency.
  always_comb begin
    sel_valid = sel_q ? src1_valid_i : src0_valid_i;
    sel_data  = sel_q ? src1_data_i  : src0_data_i;
    fwd       = (state_q == S_STREAM) && sel_valid;
  end

  assign filt_valid_o = fwd;
  assign filt_data_o  = fwd ? sel_data : '0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    timeout_d = timeout_q;
    clr_cnt_d = clr_cnt_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    tmr_d     = tmr_q;

    if ((state_q == S_STREAM || state_q == S_DRAIN) && filt_out_valid_i && (out_cnt_q != '1)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          sel_d     = (req_i == 2'b11) ? ~last_q : req_i[1];
          clr_cnt_d = CLR_W'(CLEAR_CYCLES - 1);
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        tmr_d     = '0;
        timeout_d = 1'b0;
        if (clr_cnt_q == '0) begin
          state_d = S_START;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      S_START: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (fwd) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_d == CNT_W'(FRAME_PIX)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (filt_done_i) begin
          state_d = S_REPORT;
        end else if (tmr_d == TMR_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_REPORT: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    grant_d      = (state_d == S_STREAM) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
    filt_rst_d   = (state_d == S_IDLE) || (state_d == S_CLEAR);
    filt_start_d = (state_d == S_START);
    frame_done_d = (state_d == S_REPORT);
    frame_src_d  = (state_d == S_REPORT) && sel_q;
    err_d        = (state_d == S_REPORT) && (timeout_d || (out_cnt_d != CNT_W'(EXP_OUT)));
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      timeout_q    <= 1'b0;
      clr_cnt_q    <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      tmr_q        <= '0;
      grant_q      <= '0;
      filt_rst_q   <= 1'b1;
      filt_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_src_q  <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      timeout_q    <= timeout_d;
      clr_cnt_q    <= clr_cnt_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tmr_q        <= tmr_d;
      grant_q      <= grant_d;
      filt_rst_q   <= filt_rst_d;
      filt_start_q <= filt_start_d;
      frame_done_q <= frame_done_d;
      frame_src_q  <= frame_src_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_o      = grant_q;
  assign filt_rst_o   = filt_rst_q;
  assign filt_start_o = filt_start_q;
  assign frame_done_o = frame_done_q;
  assign frame_src_o  = frame_src_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_median_frame_scheduler.sv
// Bench for median_frame_scheduler: timeline model plus per-cycle compare.
module tb_median_frame_scheduler;

  localparam int L       = 4;
  localparam int H       = 3;
  localparam int CC      = 2;
  localparam int TO      = 16;
  localparam int PIX     = L * H;
  localparam int EXP_OUT = (L - 1) * (H - 1);
  localparam int DW      = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_i = 2'b00;
  logic          src0_valid_i = 1'b0;
  logic [DW-1:0] src0_data_i = '0;
  logic          src1_valid_i = 1'b0;
  logic [DW-1:0] src1_data_i = '0;
  logic          filt_out_valid_i = 1'b0;
  logic          filt_done_i = 1'b0;
  logic [1:0]    grant_o;
  logic          filt_rst_o;
  logic          filt_start_o;
  logic          filt_valid_o;
  logic [DW-1:0] filt_data_o;
  logic          frame_done_o;
  logic          frame_src_o;
  logic          err_o;
  logic          busy_o;

  median_frame_scheduler #(
    .IMAGE_LEN      (L),
    .IMAGE_HEIGHT   (H),
    .PIXEL_W        (8),
    .CLEAR_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req_i),
    .grant_o          (grant_o),
    .src0_valid_i     (src0_valid_i),
    .src0_data_i      (src0_data_i),
    .src1_valid_i     (src1_valid_i),
    .src1_data_i      (src1_data_i),
    .filt_rst_o       (filt_rst_o),
    .filt_start_o     (filt_start_o),
    .filt_valid_o     (filt_valid_o),
    .filt_data_o      (filt_data_o),
    .filt_out_valid_i (filt_out_valid_i),
    .filt_done_i      (filt_done_i),
    .frame_done_o     (frame_done_o),
    .frame_src_o      (frame_src_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic          exp_busy  = 1'b0;
  logic          exp_rst   = 1'b1;
  logic          exp_start = 1'b0;
  logic [1:0]    exp_grant = 2'b00;
  logic          exp_fv    = 1'b0;
  logic [DW-1:0] exp_fd    = '0;
  logic          exp_done  = 1'b0;
  logic          exp_err   = 1'b0;
  logic          exp_src   = 1'b0;
  bit            m_last    = 1'b1;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy_o",       32'(busy_o),       32'(exp_busy));
      cmp("filt_rst_o",   32'(filt_rst_o),   32'(exp_rst));
      cmp("filt_start_o", 32'(filt_start_o), 32'(exp_start));
      cmp("grant_o",      32'(grant_o),      32'(exp_grant));
      cmp("filt_valid_o", 32'(filt_valid_o), 32'(exp_fv));
      cmp("filt_data_o",  32'(filt_data_o),  32'(exp_fd));
      cmp("frame_done_o", 32'(frame_done_o), 32'(exp_done));
      cmp("err_o",        32'(err_o),        32'(exp_err));
      if (exp_done) cmp("frame_src_o", 32'(frame_src_o), 32'(exp_src));
    end
  end

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_rst = 1'b1; exp_start = 1'b0; exp_grant = 2'b00;
    exp_fv = 1'b0; exp_fd = '0; exp_done = 1'b0; exp_err = 1'b0; exp_src = 1'b0;
  endtask

  task automatic idle_cycles(input int k, input logic r);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      rst = r; req_i = 2'b00; src0_valid_i = 1'b0; src1_valid_i = 1'b0;
      filt_out_valid_i = 1'b0; filt_done_i = 1'b0;
      if (r) m_last = 1'b1;
      set_idle_exp();
      chk_en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(
    input  logic [1:0] req,
    input  logic [1:0] req_after,
    input  int         npix,
    input  bit         gappy,
    input  int         nout,
    input  bit         done_en,
    input  int         abort_after,
    output int         fwd_seen,
    output int         rst_busy_seen,
    output int         start_seen,
    output int         drain_len,
    output logic       seen_err,
    output logic       seen_src
  );
    int src, acc, sent, outs, stream_end, report_n, drop_n, done_n;
    bit exp_err_m, aborting, finish, had_grant;
    logic [DW-1:0] d;
    src = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
    exp_err_m = !done_en || (nout != EXP_OUT);
    acc = 0; sent = 0; outs = 0; stream_end = -1; report_n = -1; drop_n = -1; done_n = -1;
    aborting = 1'b0; finish = 1'b0; had_grant = 1'b0;
    fwd_seen = 0; rst_busy_seen = 0; start_seen = 0; seen_err = 1'bx; seen_src = 1'bx;
    for (int n = 0; n < 400 && !finish; n++) begin
      @(posedge clk); #1;
      rst = 1'b0; filt_out_valid_i = 1'b0; filt_done_i = 1'b0;
      src0_valid_i = 1'b0; src1_valid_i = 1'b0;
      src0_data_i = DW'($urandom); src1_data_i = DW'($urandom);
      if (src == 0) src1_valid_i = 1'b1; else src0_valid_i = 1'b1;
      if (n == 0) req_i = req;
      else if (n == CC + 2) req_i = req_after;
      exp_busy = 1'b1; exp_rst = 1'b0; exp_start = 1'b0; exp_grant = 2'b00;
      exp_fv = 1'b0; exp_fd = '0; exp_done = 1'b0; exp_err = 1'b0; exp_src = 1'b0;
      if (aborting) begin
        set_idle_exp();
        req_i = 2'b00; m_last = 1'b1; finish = 1'b1;
      end else if (n == 0) begin
        exp_busy = 1'b0; exp_rst = 1'b1;
      end else if (n <= CC) begin
        exp_rst = 1'b1;
      end else if (n == CC + 1) begin
        exp_start = 1'b1;
        if (src == 0) src0_valid_i = 1'b1; else src1_valid_i = 1'b1;
      end else if (stream_end < 0) begin
        exp_grant = (src == 0) ? 2'b01 : 2'b10;
        if (abort_after > 0 && acc == abort_after) begin
          rst = 1'b1; aborting = 1'b1;
        end else if (sent < npix && (!gappy || n % 2 == 1)) begin
          d = DW'($urandom);
          if (src == 0) begin src0_valid_i = 1'b1; src0_data_i = d; end
          else begin src1_valid_i = 1'b1; src1_data_i = d; end
          exp_fv = 1'b1; exp_fd = d; sent++; acc++;
          if (acc == PIX) stream_end = n + 1;
        end
        if (outs < nout) begin filt_out_valid_i = 1'b1; outs++; end
        if (n == CC + 2) filt_done_i = 1'b1;
      end else begin
        report_n = done_en ? stream_end + 2 : stream_end + TO;
        if (n == report_n) begin
          exp_done = 1'b1; exp_err = exp_err_m; exp_src = src[0];
          m_last = src[0]; finish = 1'b1;
        end else if (done_en && n == stream_end + 1) begin
          filt_done_i = 1'b1;
        end
        if (sent < npix) begin
          if (src == 0) src0_valid_i = 1'b1; else src1_valid_i = 1'b1;
          sent++;
        end
      end
      @(negedge clk);
      if (filt_valid_o) fwd_seen++;
      if (busy_o && filt_rst_o) rst_busy_seen++;
      if (filt_start_o) start_seen++;
      if (grant_o != 2'b00) had_grant = 1'b1;
      else if (had_grant && drop_n < 0) drop_n = n;
      if (frame_done_o) begin done_n = n; seen_err = err_o; seen_src = frame_src_o; end
    end
    if (!finish) begin
      n_vec++; n_bad++;
      $display("FAIL frame_bound: frame did not complete within 400 cycles");
    end
    drain_len = done_n - drop_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, rb, st, dl;
    logic e, s;
    idle_cycles(3, 1'b1);
    idle_cycles(2, 1'b0);

    // both sources requesting: src0 first from reset, then src1
    run_frame(2'b11, 2'b11, 12, 1'b0, 6, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s2_f1_src", 32'(s), 32'd0);
    cmp("s2_f1_err", 32'(e), 32'd0);
    run_frame(2'b11, 2'b00, 12, 1'b0, 6, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s2_f2_src", 32'(s), 32'd1);
    cmp("s2_f2_err", 32'(e), 32'd0);

    // single src0 frame
    run_frame(2'b01, 2'b00, 12, 1'b0, 6, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s1_fwd",      32'(f),  32'd12);
    cmp("s1_clear",    32'(rb), 32'd2);
    cmp("s1_start",    32'(st), 32'd1);
    cmp("s1_drain",    32'(dl), 32'd2);
    cmp("s1_src",      32'(s),  32'd0);
    cmp("s1_err",      32'(e),  32'd0);

    // 15 pixels offered, only 12 forwarded
    run_frame(2'b01, 2'b00, 15, 1'b0, 6, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s3_fwd", 32'(f), 32'd12);
    cmp("s3_err", 32'(e), 32'd0);

    // filter never signals done, gappy src1 stream
    run_frame(2'b10, 2'b00, 12, 1'b1, 6, 1'b0, 0, f, rb, st, dl, e, s);
    cmp("s4_fwd",   32'(f),  32'd12);
    cmp("s4_drain", 32'(dl), 32'd16);
    cmp("s4_err",   32'(e),  32'd1);
    cmp("s4_src",   32'(s),  32'd1);

    // filter produces 5 outputs instead of 6
    run_frame(2'b01, 2'b00, 12, 1'b0, 5, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s5_err", 32'(e), 32'd1);

    // reset after 6 pixels, then a fresh src1 frame
    run_frame(2'b01, 2'b00, 12, 1'b0, 6, 1'b1, 6, f, rb, st, dl, e, s);
    cmp("s6_fwd_before_rst", 32'(f), 32'd6);
    cmp("s6_busy",  32'(busy_o),     32'd0);
    cmp("s6_frst",  32'(filt_rst_o), 32'd1);
    cmp("s6_grant", 32'(grant_o),    32'd0);
    run_frame(2'b10, 2'b00, 12, 1'b0, 6, 1'b1, 0, f, rb, st, dl, e, s);
    cmp("s6_fwd", 32'(f), 32'd12);
    cmp("s6_err", 32'(e), 32'd0);
    cmp("s6_src", 32'(s), 32'd1);

    idle_cycles(2, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
